// File: rtl/pong_pkg.sv
// pong_pkg: shared board constants, state/direction encodings and the paddle hit-window test.
package pong_pkg;
  localparam int c_GAME_WIDTH = 40;
  localparam int c_GAME_HEIGHT = 30;
  localparam logic [5:0] c_BALL_X_INIT = 6'd20;
  localparam logic [5:0] c_BALL_Y_INIT = 6'd15;
  localparam logic [5:0] c_X_MAX = 6'(c_GAME_WIDTH - 1);
  localparam logic [5:0] c_Y_MAX = 6'(c_GAME_HEIGHT - 1);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUNNING = 2'd1;
  localparam logic [1:0] c_SCORE = 2'd2;
  typedef enum logic [1:0] {S_IDLE = c_IDLE, S_RUNNING = c_RUNNING, S_SCORE = c_SCORE} state_t;
  typedef enum logic {X_LEFT = 1'b0, X_RIGHT = 1'b1} x_dir_t;
  typedef enum logic {Y_UP = 1'b0, Y_DOWN = 1'b1} y_dir_t;
  // 7-bit compare so top+h cannot wrap past row 63
  function automatic logic in_window(input logic [5:0] y, input logic [5:0] top, input logic [6:0] h);
    return {1'b0, y} >= {1'b0, top} && {1'b0, y} <= {1'b0, top} + h;
  endfunction
endpackage

// File: rtl/pong_ball_ctrl_if.sv
// pong_ball_ctrl_if: paddle/scan inputs and ball/score outputs of the ball stage.
interface pong_ball_ctrl_if;
  logic i_Game_Start;
  logic [5:0] i_Col_Count_Div;
  logic [5:0] i_Row_Count_Div;
  logic [5:0] i_P1_Paddle_Y;
  logic [5:0] i_P2_Paddle_Y;
  logic o_Draw_Ball;
  logic [5:0] o_Ball_X;
  logic [5:0] o_Ball_Y;
  logic o_P1_Score_Pulse;
  logic o_P2_Score_Pulse;
  logic o_Game_Active;
  modport master (
    output i_Game_Start, i_Col_Count_Div, i_Row_Count_Div, i_P1_Paddle_Y, i_P2_Paddle_Y,
    input o_Draw_Ball, o_Ball_X, o_Ball_Y, o_P1_Score_Pulse, o_P2_Score_Pulse, o_Game_Active
  );
  modport slave (
    input i_Game_Start, i_Col_Count_Div, i_Row_Count_Div, i_P1_Paddle_Y, i_P2_Paddle_Y,
    output o_Draw_Ball, o_Ball_X, o_Ball_Y, o_P1_Score_Pulse, o_P2_Score_Pulse, o_Game_Active
  );
endinterface

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: enabled 0..c_TERM counter; tick on terminal count, held at 0 while disabled.
module pong_tick_gen #(
  parameter int c_TERM = 1250000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_En,
  output logic o_Tick
);
  localparam int W = $clog2(c_TERM + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_Tick = i_En && cnt_q == W'(c_TERM);
  assign cnt_d = (!i_En || o_Tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball motion, wall/paddle bounce, scoring pulses and registered ball draw strobe.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_P1_PADDLE_X = 0,
  parameter int c_P2_PADDLE_X = 39,
  parameter int c_BALL_SPEED = 1250000
) (
  input logic i_Clk,
  input logic i_Rst_n,
  pong_ball_ctrl_if.slave bus
);
  localparam logic [5:0] P1_EDGE = 6'(c_P1_PADDLE_X + 1);
  localparam logic [5:0] P2_EDGE = 6'(c_P2_PADDLE_X - 1);
  localparam logic [6:0] PH = 7'(c_PADDLE_HEIGHT);
  state_t state_q, state_d;
  x_dir_t xdir_q, xdir_d;
  y_dir_t ydir_q, ydir_d;
  logic [5:0] x_q, x_d, y_q, y_d;
  logic p1_q, p1_d, p2_q, p2_d, draw_q, draw_d;
  logic tick, p1_hit, p2_hit;
  pong_tick_gen #(.c_TERM(c_BALL_SPEED)) u_tick (
    .i_Clk(i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_En(state_q == S_RUNNING),
    .o_Tick(tick)
  );
  assign p1_hit = in_window(y_q, bus.i_P1_Paddle_Y, PH);
  assign p2_hit = in_window(y_q, bus.i_P2_Paddle_Y, PH);
  always_comb begin
    state_d = state_q;
    xdir_d = xdir_q;
    ydir_d = ydir_q;
    x_d = x_q;
    y_d = y_q;
    p1_d = 1'b0;
    p2_d = 1'b0;
    draw_d = bus.i_Col_Count_Div == x_q && bus.i_Row_Count_Div == y_q;
    if (state_q == S_IDLE && bus.i_Game_Start) state_d = S_RUNNING;
    else if (state_q == S_SCORE) begin
      state_d = S_IDLE;
      x_d = c_BALL_X_INIT;
      y_d = c_BALL_Y_INIT;
    end else if (state_q == S_RUNNING && tick) begin
      if (y_q == 6'd0 && ydir_q == Y_UP) begin
        ydir_d = Y_DOWN;
        y_d = 6'd1;
      end else if (y_q == c_Y_MAX && ydir_q == Y_DOWN) begin
        ydir_d = Y_UP;
        y_d = y_q - 6'd1;
      end else y_d = ydir_q == Y_DOWN ? y_q + 6'd1 : y_q - 6'd1;
      // on a score xdir already points at the conceding player, which is the next serve direction
      if (xdir_q == X_LEFT) begin
        if (x_q == 6'd0) begin
          state_d = S_SCORE;
          p2_d = 1'b1;
        end else if (x_q == P1_EDGE && p1_hit) begin
          xdir_d = X_RIGHT;
          x_d = x_q + 6'd1;
        end else x_d = x_q - 6'd1;
      end else begin
        if (x_q == c_X_MAX) begin
          state_d = S_SCORE;
          p1_d = 1'b1;
        end else if (x_q == P2_EDGE && p2_hit) begin
          xdir_d = X_LEFT;
          x_d = x_q - 6'd1;
        end else x_d = x_q + 6'd1;
      end
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      xdir_q <= X_RIGHT;
      ydir_q <= Y_DOWN;
      x_q <= c_BALL_X_INIT;
      y_q <= c_BALL_Y_INIT;
      p1_q <= 1'b0;
      p2_q <= 1'b0;
      draw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xdir_q <= xdir_d;
      ydir_q <= ydir_d;
      x_q <= x_d;
      y_q <= y_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      draw_q <= draw_d;
    end
  assign bus.o_Ball_X = x_q;
  assign bus.o_Ball_Y = y_q;
  assign bus.o_P1_Score_Pulse = p1_q;
  assign bus.o_P2_Score_Pulse = p2_q;
  assign bus.o_Draw_Ball = draw_q;
  assign bus.o_Game_Active = state_q == S_RUNNING;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: table-driven rallies with a per-tick ball model feeding a scoreboard queue.
module tb_pong_ball_ctrl;
  localparam int SPD = 3;
  localparam int PH = 6;
  typedef struct { int p1y; int p2y; int nt; int ex; int ey; int sc; int sx; int sy; } vec_t;
  typedef struct { int x; int y; bit p1; bit p2; bit act; } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int mx, my, p1y, p2y;
  bit mright, mdown;
  sb_t q[$];
  vec_t vecs[5];
  pong_ball_ctrl_if bus();
  pong_ball_ctrl #(.c_BALL_SPEED(SPD)) dut (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic model_tick(output int sc);
    int nx, ny;
    nx = mx;
    sc = 0;
    if (my == 0 && !mdown) begin mdown = 1; ny = 1; end
    else if (my == 29 && mdown) begin mdown = 0; ny = 28; end
    else ny = mdown ? my + 1 : my - 1;
    if (!mright) begin
      if (mx == 0) sc = 2;
      else if (mx == 1 && my >= p1y && my <= p1y + PH) begin mright = 1; nx = 2; end
      else nx = mx - 1;
    end else begin
      if (mx == 39) sc = 1;
      else if (mx == 38 && my >= p2y && my <= p2y + PH) begin mright = 0; nx = 37; end
      else nx = mx + 1;
    end
    mx = nx;
    my = ny;
  endtask
  task automatic step(input int pre);
    sb_t e;
    int sc;
    model_tick(sc);
    e.x = mx; e.y = my; e.p1 = sc == 1; e.p2 = sc == 2; e.act = sc == 0;
    q.push_back(e);
    repeat (SPD + 1 - pre) @(posedge clk);
    #1;
    e = q.pop_front();
    check("ball_x", bus.o_Ball_X, e.x);
    check("ball_y", bus.o_Ball_Y, e.y);
    check("p1_pulse", bus.o_P1_Score_Pulse, e.p1);
    check("p2_pulse", bus.o_P2_Score_Pulse, e.p2);
    check("active", bus.o_Game_Active, e.act);
    if (sc != 0) begin mx = 20; my = 15; mright = sc == 1; end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_x"}, bus.o_Ball_X, 20);
    check({tag, "_y"}, bus.o_Ball_Y, 15);
    check({tag, "_active"}, bus.o_Game_Active, 0);
    check({tag, "_p1"}, bus.o_P1_Score_Pulse, 0);
    check({tag, "_p2"}, bus.o_P2_Score_Pulse, 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.i_Game_Start = 1'b0;
    #1;
    check_idle("rst");
    check("rst_draw", bus.o_Draw_Ball, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mx = 20; my = 15; mright = 1; mdown = 1;
    q.delete();
  endtask
  task automatic start();
    bus.i_Game_Start = 1'b1;
    @(posedge clk);
    #1 bus.i_Game_Start = 1'b0;
    check("start_active", bus.o_Game_Active, 1);
  endtask
  task automatic run_to(input int nt, input bit draw_chk);
    do_reset();
    start();
    repeat (SPD) @(posedge clk);
    #1;
    check("hold_x", bus.o_Ball_X, 20);
    check("hold_y", bus.o_Ball_Y, 15);
    step(SPD);
    check("first_x", bus.o_Ball_X, 21);
    check("first_y", bus.o_Ball_Y, 16);
    if (draw_chk) begin
      bus.i_Col_Count_Div = 6'd21; bus.i_Row_Count_Div = 6'd16;
      @(posedge clk); #1 check("draw_hit", bus.o_Draw_Ball, 1);
      bus.i_Col_Count_Div = 6'd22;
      @(posedge clk); #1 check("draw_col_right", bus.o_Draw_Ball, 0);
      bus.i_Col_Count_Div = 6'd20;
      @(posedge clk); #1 check("draw_col_left", bus.o_Draw_Ball, 0);
      bus.i_Col_Count_Div = 6'd0; bus.i_Row_Count_Div = 6'd0;
    end
    for (int n = 2; n <= nt; n++) begin
      step((n == 2 && draw_chk) ? 3 : 0);
      if (n == 15) begin
        check("wall_x", bus.o_Ball_X, 35);
        check("wall_y", bus.o_Ball_Y, 28);
      end
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    bus.i_Game_Start = 1'b0;
    bus.i_Col_Count_Div = 6'd0;
    bus.i_Row_Count_Div = 6'd0;
    bus.i_P1_Paddle_Y = 6'd0;
    bus.i_P2_Paddle_Y = 6'd0;
    vecs[0] = '{10, 20, 56, 2, 13, 0, 0, 0};
    vecs[1] = '{6, 20, 56, 2, 13, 0, 0, 0};
    vecs[2] = '{13, 20, 56, 0, 13, 2, 19, 16};
    vecs[3] = '{5, 20, 56, 0, 13, 2, 19, 16};
    vecs[4] = '{10, 0, 19, 39, 24, 1, 21, 14};
    for (int i = 0; i < 5; i++) begin
      p1y = vecs[i].p1y;
      p2y = vecs[i].p2y;
      bus.i_P1_Paddle_Y = 6'(p1y);
      bus.i_P2_Paddle_Y = 6'(p2y);
      run_to(vecs[i].nt, i == 0);
      check("vec_x", bus.o_Ball_X, vecs[i].ex);
      check("vec_y", bus.o_Ball_Y, vecs[i].ey);
      if (vecs[i].sc != 0) begin
        step(0);
        @(posedge clk);
        #1 check_idle("after_score");
        repeat (3) @(posedge clk);
        #1 check_idle("idle_hold");
        start();
        step(0);
        check("serve_x", bus.o_Ball_X, vecs[i].sx);
        check("serve_y", bus.o_Ball_Y, vecs[i].sy);
      end else step(0);
    end
    p1y = 13;
    p2y = 20;
    bus.i_P1_Paddle_Y = 6'd13;
    bus.i_P2_Paddle_Y = 6'd20;
    run_to(56, 0);
    check("pre_rst_x", bus.o_Ball_X, 0);
    repeat (SPD) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle("mid_rst");
    @(posedge clk);
    #1 check_idle("mid_rst_edge");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check_idle("post_rst");
    mx = 20; my = 15; mright = 1; mdown = 1;
    start();
    step(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
